// File: rtl/micro_sequencer_if.sv
// Bundle of the sequencer's control-panel inputs, decode inputs and status outputs.
// The master side (front panel / test harness) drives the inputs; the sequencer is the slave.
interface micro_sequencer_if;
  logic        run_enable;
  logic        step_req;
  logic [3:0]  opcode;
  logic        carry_in;
  logic        zero_in;
  logic [15:0] ctrl;
  logic        load_en;
  logic [2:0]  step;
  logic        halted;
  logic        instr_done;

  modport master (
    output run_enable, step_req, opcode, carry_in, zero_in,
    input  ctrl, load_en, step, halted, instr_done
  );

  modport slave (
    input  run_enable, step_req, opcode, carry_in, zero_in,
    output ctrl, load_en, step, halted, instr_done
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-sequencer for the 8-bit Eater-style CPU.
// Keeps the T-state counter (0..4), produces one load strobe per micro-step either from the
// auto-run divider or from rising edges of the manual step button, and decodes
// opcode/step/latched flags into the 16-bit control word.
// Control word bit order: {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}.
module micro_sequencer #(
  parameter int RUN_DIV   = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic             system_clock,
  input  logic             clr,
  micro_sequencer_if.slave bus
);

  localparam int              DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_state_t;

  step_state_t      step_reg, step_next;
  logic             halted_reg, halted_next;
  logic             carry_reg, carry_next;
  logic             zero_reg, zero_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             step_req_d_reg;

  logic             step_edge;
  logic             tick;
  logic             advance;
  logic             wrap;
  logic [2:0]       step_plus;
  logic [15:0]      word_now;
  logic [15:0]      word_after;
  logic [15:0]      ctrl_word;
  logic             done_pulse;

  // Microcode ROM: control word for a given opcode and T-state. Steps beyond 4 and
  // absent micro-steps decode to zero, which is what lets short instructions end early.
  function automatic logic [15:0] micro_word(input logic [3:0] op, input logic [2:0] s,
                                             input logic cq, input logic zq);
    logic [15:0] w;
    w = 16'h0000;
    case (s)
      3'd0: w = C_CO | C_MI;
      3'd1: w = C_RO | C_II | C_CE;
      3'd2: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: w = C_IO | C_MI;
          4'h5:                   w = C_IO | C_AI;
          4'h6:                   w = C_IO | C_J;
          4'h7:                   w = cq ? (C_IO | C_J) : 16'h0000;
          4'h8:                   w = zq ? (C_IO | C_J) : 16'h0000;
          4'hE:                   w = C_AO | C_OI;
          4'hF:                   w = C_HLT;
          default:                w = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          4'h1:       w = C_RO | C_AI;
          4'h2, 4'h3: w = C_RO | C_BI;
          4'h4:       w = C_AO | C_RI;
          default:    w = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          4'h2:    w = C_EO | C_AI | C_FI;
          4'h3:    w = C_EO | C_AI | C_SU | C_FI;
          default: w = 16'h0000;
        endcase
      end
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Auto-run divider: counts only while running, so a fresh run always waits a full period.
  always_comb begin
    div_cnt_next = '0;
    if (bus.run_enable && (div_cnt_reg != DIV_LAST)) begin
      div_cnt_next = div_cnt_reg + DIV_W'(1);
    end
  end

  // Advance qualification: a tick and a button edge in the same cycle merge into one step.
  always_comb begin
    step_edge = bus.step_req & ~step_req_d_reg;
    tick      = bus.run_enable & (div_cnt_reg == DIV_LAST);
    advance   = ~halted_reg & (tick | step_edge);
  end

  // Decode of the current control word and the early-end lookahead on the next step.
  always_comb begin
    step_plus  = step_reg + 3'd1;
    word_now   = micro_word(bus.opcode, step_reg, carry_reg, zero_reg);
    word_after = micro_word(bus.opcode, step_plus, carry_reg, zero_reg);
    ctrl_word  = halted_reg ? C_HLT : word_now;
    wrap       = (step_reg == T4) ||
                 (EARLY_END && (step_reg >= T2) && (word_after == 16'h0000));
  end

  // Next-state logic for the T-state FSM, halt latch and flag latches.
  always_comb begin
    step_next   = step_reg;
    halted_next = halted_reg;
    carry_next  = carry_reg;
    zero_next   = zero_reg;
    done_pulse  = 1'b0;
    if (advance) begin
      if (ctrl_word[15]) begin
        halted_next = 1'b1;
      end else begin
        if (ctrl_word[0]) begin
          carry_next = bus.carry_in;
          zero_next  = bus.zero_in;
        end
        step_next  = wrap ? T0 : step_state_t'(step_plus);
        done_pulse = wrap;
      end
    end
  end

  // State registers; the button history resets high so a held button causes no step.
  always_ff @(posedge system_clock or posedge clr) begin
    if (clr) begin
      step_reg       <= T0;
      halted_reg     <= 1'b0;
      carry_reg      <= 1'b0;
      zero_reg       <= 1'b0;
      div_cnt_reg    <= '0;
      step_req_d_reg <= 1'b1;
    end else begin
      step_reg       <= step_next;
      halted_reg     <= halted_next;
      carry_reg      <= carry_next;
      zero_reg       <= zero_next;
      div_cnt_reg    <= div_cnt_next;
      step_req_d_reg <= bus.step_req;
    end
  end

  // Output drive.
  always_comb begin
    bus.ctrl       = ctrl_word;
    bus.load_en    = advance;
    bus.step       = step_reg;
    bus.halted     = halted_reg;
    bus.instr_done = done_pulse;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: expected micro-steps are queued when a step is
// requested and compared when the sequencer raises load_en.
module tb_micro_sequencer;

  logic system_clock;
  logic clr;
  int   checks;
  int   failures;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  micro_sequencer_if bus_a ();
  micro_sequencer_if bus_b ();

  micro_sequencer #(.RUN_DIV(4), .EARLY_END(1'b1)) dut_a (
    .system_clock (system_clock),
    .clr          (clr),
    .bus          (bus_a.slave)
  );

  micro_sequencer #(.RUN_DIV(4), .EARLY_END(1'b0)) dut_b (
    .system_clock (system_clock),
    .clr          (clr),
    .bus          (bus_b.slave)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic [2:0] s, input logic d);
    exp_t e;
    e.ctrl = c;
    e.step = s;
    e.done = d;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] rd_ctrl(input int sel);
    return (sel != 0) ? bus_b.ctrl : bus_a.ctrl;
  endfunction
  function automatic logic [2:0] rd_step(input int sel);
    return (sel != 0) ? bus_b.step : bus_a.step;
  endfunction
  function automatic logic rd_le(input int sel);
    return (sel != 0) ? bus_b.load_en : bus_a.load_en;
  endfunction
  function automatic logic rd_done(input int sel);
    return (sel != 0) ? bus_b.instr_done : bus_a.instr_done;
  endfunction

  task automatic set_req(input int sel, input logic v);
    if (sel != 0) bus_b.step_req = v;
    else          bus_a.step_req = v;
  endtask

  // Compare the current outputs of one DUT against the next queued micro-step.
  task automatic compare_front(input int sel, input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_ctrl"}, rd_ctrl(sel), e.ctrl);
      check({tag, "_step"}, {13'b0, rd_step(sel)}, {13'b0, e.step});
      check({tag, "_done"}, {15'b0, rd_done(sel)}, {15'b0, e.done});
    end
  endtask

  // One manual micro-step via a button edge.
  task automatic step_once(input int sel);
    @(posedge system_clock); #1;
    set_req(sel, 1'b1);
    @(negedge system_clock);
    check("man_load_en_hi", {15'b0, rd_le(sel)}, 16'd1);
    compare_front(sel, "man");
    @(posedge system_clock); #1;
    set_req(sel, 1'b0);
    @(negedge system_clock);
    check("man_load_en_lo", {15'b0, rd_le(sel)}, 16'd0);
  endtask

  // Wait (bounded) for an auto-run strobe on DUT A and report the cycles it took.
  task automatic wait_adv(output int n);
    n = 0;
    do begin
      @(negedge system_clock);
      n++;
    end while (!bus_a.load_en && n < 20);
    check("auto_strobe_seen", {15'b0, bus_a.load_en}, 16'd1);
  endtask

  initial begin
    int n;
    int le_count;
    checks   = 0;
    failures = 0;

    clr = 1'b1;
    bus_a.run_enable = 1'b0; bus_a.step_req = 1'b1; bus_a.opcode = 4'h0;
    bus_a.carry_in = 1'b0;   bus_a.zero_in = 1'b0;
    bus_b.run_enable = 1'b0; bus_b.step_req = 1'b1; bus_b.opcode = 4'h0;
    bus_b.carry_in = 1'b0;   bus_b.zero_in = 1'b0;

    // Reset with the button held through release: no step may be taken.
    repeat (3) @(posedge system_clock);
    #1 clr = 1'b0;
    repeat (3) @(negedge system_clock);
    check("rst_step", {13'b0, bus_a.step}, 16'd0);
    check("rst_ctrl", bus_a.ctrl, 16'h4004);
    check("rst_load_en", {15'b0, bus_a.load_en}, 16'd0);
    check("rst_done", {15'b0, bus_a.instr_done}, 16'd0);
    check("rst_halted", {15'b0, bus_a.halted}, 16'd0);
    check("rst_b_ctrl", bus_b.ctrl, 16'h4004);
    bus_a.step_req = 1'b0;
    bus_b.step_req = 1'b0;

    // EARLY_END=0 instance: JC not taken still runs all five steps.
    bus_b.opcode = 4'h7;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0);
    push(16'h0000, 3'd2, 1'b0); push(16'h0000, 3'd3, 1'b0); push(16'h0000, 3'd4, 1'b1);
    repeat (5) step_once(1);
    check("b_jc_back_to_0", {13'b0, bus_b.step}, 16'd0);

    // LDA: ends after step 3.
    bus_a.opcode = 4'h1;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0);
    push(16'h4800, 3'd2, 1'b0); push(16'h1200, 3'd3, 1'b1);
    repeat (4) step_once(0);
    check("lda_back_to_0", {13'b0, bus_a.step}, 16'd0);

    // SUB latching carry=1, zero=1 on its final step.
    bus_a.opcode = 4'h3; bus_a.carry_in = 1'b1; bus_a.zero_in = 1'b1;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0);
    push(16'h4800, 3'd2, 1'b0); push(16'h1020, 3'd3, 1'b0); push(16'h02C1, 3'd4, 1'b1);
    repeat (5) step_once(0);
    bus_a.carry_in = 1'b0; bus_a.zero_in = 1'b0;

    // JC and JZ taken on the latched flags although live flags are now 0.
    bus_a.opcode = 4'h7;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0); push(16'h0802, 3'd2, 1'b1);
    repeat (3) step_once(0);
    bus_a.opcode = 4'h8;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0); push(16'h0802, 3'd2, 1'b1);
    repeat (3) step_once(0);

    // ADD clears the flags; following JC is not taken and ends in three steps.
    bus_a.opcode = 4'h2;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0);
    push(16'h4800, 3'd2, 1'b0); push(16'h1020, 3'd3, 1'b0); push(16'h0281, 3'd4, 1'b1);
    repeat (5) step_once(0);
    bus_a.opcode = 4'h7;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0); push(16'h0000, 3'd2, 1'b1);
    repeat (3) step_once(0);

    // Auto-run NOP: one strobe every 4 cycles.
    bus_a.opcode = 4'h0;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0); push(16'h0000, 3'd2, 1'b1);
    @(posedge system_clock); #1;
    bus_a.run_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_adv(n);
      check("auto_period", 16'(n), 16'd4);
      compare_front(0, "auto");
    end

    // Button edge coinciding with a tick yields exactly one advance.
    repeat (4) @(posedge system_clock);
    #1 bus_a.step_req = 1'b1;
    @(negedge system_clock);
    check("coinc_load_en", {15'b0, bus_a.load_en}, 16'd1);
    check("coinc_ctrl", bus_a.ctrl, 16'h4004);
    @(posedge system_clock); #1;
    bus_a.run_enable = 1'b0;
    check("coinc_single_step", {13'b0, bus_a.step}, 16'd1);
    @(negedge system_clock);
    check("coinc_load_en_lo", {15'b0, bus_a.load_en}, 16'd0);
    @(posedge system_clock); #1;
    bus_a.step_req = 1'b0;
    push(16'h1408, 3'd1, 1'b0); push(16'h0000, 3'd2, 1'b1);
    repeat (2) step_once(0);

    // HLT: halts on its step-2 strobe and ignores all further requests.
    bus_a.opcode = 4'hF;
    push(16'h4004, 3'd0, 1'b0); push(16'h1408, 3'd1, 1'b0); push(16'h8000, 3'd2, 1'b0);
    repeat (3) step_once(0);
    check("hlt_halted", {15'b0, bus_a.halted}, 16'd1);
    check("hlt_ctrl", bus_a.ctrl, 16'h8000);
    check("hlt_step", {13'b0, bus_a.step}, 16'd2);
    @(posedge system_clock); #1;
    bus_a.step_req = 1'b1;
    @(negedge system_clock);
    check("hlt_btn_no_strobe", {15'b0, bus_a.load_en}, 16'd0);
    @(posedge system_clock); #1;
    bus_a.step_req = 1'b0;
    bus_a.run_enable = 1'b1;
    le_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge system_clock);
      if (bus_a.load_en) le_count++;
    end
    check("hlt_auto_no_strobe", 16'(le_count), 16'd0);
    @(posedge system_clock); #1;
    bus_a.run_enable = 1'b0;

    // Asynchronous clear releases the halt immediately.
    @(posedge system_clock); #1;
    clr = 1'b1;
    #2;
    check("clr_step", {13'b0, bus_a.step}, 16'd0);
    check("clr_halted", {15'b0, bus_a.halted}, 16'd0);
    check("clr_ctrl", bus_a.ctrl, 16'h4004);
    @(negedge system_clock);
    clr = 1'b0;
    check("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
